// File: rtl/pulse_divider_pkg.sv
// pulse_divider_pkg: shared widths and types for the pulse divider
package pulse_divider_pkg;
  localparam int DIV_W = 32;
  localparam int SYNC_STAGES = 2;
  typedef logic [DIV_W-1:0] div_t;
endpackage

// File: rtl/serial_div_loader.sv
// serial_div_loader: synchronizes the serial divisor port, shifts bits in MSB-first and commits on window close
module serial_div_loader
  import pulse_divider_pkg::*;
#(
  parameter int DIV_W = pulse_divider_pkg::DIV_W,
  parameter int SYNC_STAGES = pulse_divider_pkg::SYNC_STAGES
) (
  input  logic             pulse_clock,
  input  logic             external_reset,
  input  logic             sr_data,
  input  logic             sr_data_clock,
  input  logic             sr_div_data_enable,
  input  logic             sr_div_data_reset,
  output logic [DIV_W-1:0] divisor,
  output logic             load
);
  logic [SYNC_STAGES-1:0] data_s, strobe_s, win_s;
  logic                   strobe_q, win_q, strobe_rise;
  logic [DIV_W-1:0]       shift;
  assign strobe_rise = strobe_s[SYNC_STAGES-1] & ~strobe_q;
  assign load = win_q & ~win_s[SYNC_STAGES-1];
  always_ff @(posedge pulse_clock) begin
    if (!external_reset) begin
      data_s   <= '0;
      strobe_s <= '0;
      win_s    <= '0;
      strobe_q <= 1'b0;
      win_q    <= 1'b0;
      shift    <= '0;
      divisor  <= '0;
    end else begin
      data_s   <= SYNC_STAGES'({data_s, sr_data});
      strobe_s <= SYNC_STAGES'({strobe_s, sr_data_clock});
      win_s    <= SYNC_STAGES'({win_s, sr_div_data_enable});
      strobe_q <= strobe_s[SYNC_STAGES-1];
      win_q    <= win_s[SYNC_STAGES-1];
      if (sr_div_data_reset) shift <= '0;
      else if (strobe_rise && win_s[SYNC_STAGES-1]) shift <= {shift[DIV_W-2:0], data_s[SYNC_STAGES-1]};
      if (load) divisor <= shift;
    end
  end
endmodule

// File: rtl/pulse_divider.sv
// pulse_divider: programmable integer divider producing a pulse train of period N from a serially loaded divisor
module pulse_divider
  import pulse_divider_pkg::*;
#(
  parameter int DIV_W = pulse_divider_pkg::DIV_W,
  parameter int SYNC_STAGES = pulse_divider_pkg::SYNC_STAGES
) (
  input  logic pulse_clock,
  input  logic external_reset,
  input  logic enable,
  input  logic sr_data,
  input  logic sr_data_clock,
  input  logic sr_div_data_enable,
  input  logic sr_div_data_reset,
  output logic divided_clock
);
  logic [DIV_W-1:0] divisor, count;
  logic             load, run;
  serial_div_loader #(.DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES)) loader (
    .pulse_clock(pulse_clock),
    .external_reset(external_reset),
    .sr_data(sr_data),
    .sr_data_clock(sr_data_clock),
    .sr_div_data_enable(sr_div_data_enable),
    .sr_div_data_reset(sr_div_data_reset),
    .divisor(divisor),
    .load(load)
  );
  assign run = !load && enable && divisor >= DIV_W'(2);
  always_ff @(posedge pulse_clock) begin
    if (!external_reset) begin
      count         <= '0;
      divided_clock <= 1'b0;
    end else begin
      divided_clock <= run && count < (divisor >> 1);
      count         <= run && count != divisor - 1'b1 ? count + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_pulse_divider.sv
// tb_pulse_divider: randomized check of the divider against a phase-index reference model
module tb_pulse_divider;
  import pulse_divider_pkg::*;
  logic pulse_clock = 0, external_reset = 0, enable = 0, sr_data = 0;
  logic sr_data_clock = 0, sr_div_data_enable = 0, sr_div_data_reset = 0;
  logic divided_clock;
  int   total = 0, bad = 0, k = 0, commit_in = 0, rises;
  div_t mdiv = '0, pending = '0, v;
  logic exp_out = 0, prev;
  pulse_divider dut (
    .pulse_clock(pulse_clock),
    .external_reset(external_reset),
    .enable(enable),
    .sr_data(sr_data),
    .sr_data_clock(sr_data_clock),
    .sr_div_data_enable(sr_div_data_enable),
    .sr_div_data_reset(sr_div_data_reset),
    .divided_clock(divided_clock)
  );
  always #5 pulse_clock = ~pulse_clock;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask
  // Output is high during the first floor(N/2) cycles of each N-cycle period counted from the last restart
  task automatic step();
    logic commit_now;
    commit_now = 0;
    @(posedge pulse_clock);
    if (!external_reset) begin
      mdiv = '0;
      k = 0;
      commit_in = 0;
      exp_out = 0;
    end else begin
      if (commit_in > 0) begin
        commit_in--;
        if (commit_in == 0) begin
          mdiv = pending;
          commit_now = 1;
        end
      end
      if (commit_now || !enable || mdiv < 2) begin
        exp_out = 0;
        k = 0;
      end else begin
        exp_out = (k % int'(mdiv)) < int'(mdiv / 2);
        k++;
      end
    end
    #1 chk("out", divided_clock, exp_out);
  endtask
  task automatic idle(int n);
    repeat (n) step();
  endtask
  task automatic shift_bits(logic [31:0] w, int n);
    sr_div_data_enable = 1;
    for (int i = n - 1; i >= 0; i--) begin
      sr_data = w[i];
      sr_data_clock = 0;
      idle(4);
      sr_data_clock = 1;
      idle(4);
    end
    sr_data_clock = 0;
    idle(4);
  endtask
  task automatic commit(div_t w);
    pending = w;
    sr_div_data_enable = 0;
    commit_in = SYNC_STAGES + 1;
    idle(4);
  endtask
  task automatic load(div_t w);
    shift_bits(w, 32);
    commit(w);
  endtask
  initial begin
    enable = 1;
    idle(3);
    chk("rst_count", dut.count, 0);
    chk("rst_div", dut.divisor, 0);
    external_reset = 1;
    idle(10);
    enable = 0;
    load(20);
    chk("div20", dut.divisor, 20);
    enable = 1;
    rises = 0;
    prev = divided_clock;
    repeat (200) begin
      step();
      if (divided_clock && !prev) rises++;
      prev = divided_clock;
    end
    chk("periods20", rises, 10);
    load(10);
    idle(40);
    chk("div10", dut.divisor, 10);
    idle(3);
    external_reset = 0;
    step();
    external_reset = 1;
    chk("rst_mid_div", dut.divisor, 0);
    idle(30);
    load(10);
    idle(30);
    load(7);
    idle(35);
    load(1);
    idle(20);
    load(0);
    idle(20);
    shift_bits(32'h0000_abcd, 16);
    sr_div_data_reset = 1;
    step();
    sr_div_data_reset = 0;
    shift_bits(32'h0000_0005, 16);
    commit(5);
    chk("sr_clear_div", dut.divisor, 5);
    idle(30);
    repeat (8) begin
      v = div_t'($urandom_range(0, 40));
      enable = 1'($urandom_range(0, 1));
      load(v);
      chk("rand_div", dut.divisor, v);
      repeat ($urandom_range(60, 150)) begin
        if ($urandom_range(0, 19) == 0) enable = ~enable;
        step();
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
